// File: rtl/lsu_ctrl.sv
// Load/store sequencer: computes ea = base + imm, checks encoding/alignment/range, issues one memory access.
// Done follows the accepted start by 1 cycle (fault), 2 (store) or 3 (load); start outside IDLE is dropped.
module lsu_ctrl #(
  parameter int unsigned MEM_ADDR_BITS = 20,
  parameter logic [31:0] CONSOLE_ADDR  = 32'h1300_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [31:0] store_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_op,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_result,
  output logic [1:0]  fault,
  output logic [31:0] fault_addr
);

  localparam logic [3:0] MEMOP_NON = 4'd0;
  localparam logic [3:0] MEMOP_LB  = 4'd1;
  localparam logic [3:0] MEMOP_LH  = 4'd2;
  localparam logic [3:0] MEMOP_LW  = 4'd3;
  localparam logic [3:0] MEMOP_LBU = 4'd4;
  localparam logic [3:0] MEMOP_LHU = 4'd5;
  localparam logic [3:0] MEMOP_SB  = 4'd6;
  localparam logic [3:0] MEMOP_SH  = 4'd7;
  localparam logic [3:0] MEMOP_SW  = 4'd8;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ALIGN   = 2'd1;
  localparam logic [1:0] FAULT_ACCESS  = 2'd2;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        is_load_q, is_load_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt, load_result_nxt, fault_addr_nxt;
  logic [3:0]  mem_op_nxt;
  logic [1:0]  fault_nxt;

  logic [31:0] ea;
  logic [3:0]  req_op;
  logic        req_legal, req_misaligned, req_console, req_out_of_range;
  logic [1:0]  req_fault;

  // Request decode; operates on the live inputs because they are only consumed in IDLE.
  always_comb begin
    ea        = base + imm;
    req_op    = MEMOP_NON;
    req_legal = 1'b1;
    if (is_store) begin
      unique case (funct3)
        3'd0:    req_op = MEMOP_SB;
        3'd1:    req_op = MEMOP_SH;
        3'd2:    req_op = MEMOP_SW;
        default: req_legal = 1'b0;
      endcase
    end else begin
      unique case (funct3)
        3'd0:    req_op = MEMOP_LB;
        3'd1:    req_op = MEMOP_LH;
        3'd2:    req_op = MEMOP_LW;
        3'd4:    req_op = MEMOP_LBU;
        3'd5:    req_op = MEMOP_LHU;
        default: req_legal = 1'b0;
      endcase
    end

    req_misaligned   = ((funct3[1:0] == 2'd1) && ea[0]) ||
                       ((funct3[1:0] == 2'd2) && (ea[1:0] != 2'b00));
    req_console      = is_store && (funct3 == 3'd0) && (ea == CONSOLE_ADDR);
    req_out_of_range = (ea[31:MEM_ADDR_BITS] != '0) && !req_console;

    if (!req_legal)            req_fault = FAULT_ILLEGAL;
    else if (req_misaligned)   req_fault = FAULT_ALIGN;
    else if (req_out_of_range) req_fault = FAULT_ACCESS;
    else                       req_fault = FAULT_NONE;
  end

  always_comb begin
    state_nxt       = state;
    is_load_nxt     = is_load_q;
    mem_op_nxt      = mem_op;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    load_result_nxt = load_result;
    fault_nxt       = fault;
    fault_addr_nxt  = fault_addr;

    unique case (state)
      IDLE: begin
        if (start) begin
          is_load_nxt = !is_store;
          fault_nxt   = req_fault;
          if (req_fault != FAULT_NONE) begin
            fault_addr_nxt = ea;
            state_nxt      = DONE;
          end else begin
            mem_op_nxt    = req_op;
            mem_addr_nxt  = ea;
            mem_wdata_nxt = store_data;
            state_nxt     = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Memory samples the op at this closing edge; drop it so it is seen exactly once.
        mem_op_nxt = MEMOP_NON;
        state_nxt  = is_load_q ? CAPTURE : DONE;
      end
      CAPTURE: begin
        // data_out is only valid for this one cycle before the memory clears it.
        load_result_nxt = mem_rdata;
        state_nxt       = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      is_load_q   <= 1'b0;
      mem_op      <= MEMOP_NON;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      load_result <= '0;
      fault       <= FAULT_NONE;
      fault_addr  <= '0;
    end else begin
      state       <= state_nxt;
      is_load_q   <= is_load_nxt;
      mem_op      <= mem_op_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      load_result <= load_result_nxt;
      fault       <= fault_nxt;
      fault_addr  <= fault_addr_nxt;
    end
  end

  assign busy = (state == ACCESS) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array data memory, cycle-scheduled reference model, directed and random requests.
module tb_lsu_ctrl;

  localparam logic [3:0] OP_NON = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] base = 32'd0, imm = 32'd0, store_data = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] mem_addr, mem_wdata, load_result, fault_addr;
  logic [3:0]  mem_op;
  logic        busy, done;
  logic [1:0]  fault;

  lsu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .imm(imm), .store_data(store_data), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_op(mem_op), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .load_result(load_result), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- data memory environment (1 MB, byte addressed) ----------------
  logic [7:0] mem_b [int];

  function automatic logic [7:0] rd_b(input logic [31:0] a);
    int key;
    key = int'({12'h000, a[19:0]});
    if (mem_b.exists(key)) return mem_b[key];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic wr_b(input logic [31:0] a, input logic [7:0] v);
    mem_b[int'({12'h000, a[19:0]})] = v;
  endtask

  function automatic logic [31:0] ld_val(input logic [3:0] op, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = rd_b(a); b1 = rd_b(a + 32'd1); b2 = rd_b(a + 32'd2); b3 = rd_b(a + 32'd3);
    case (op)
      OP_LB:   return {{24{b0[7]}}, b0};
      OP_LH:   return {{16{b1[7]}}, b1, b0};
      OP_LW:   return {b3, b2, b1, b0};
      OP_LBU:  return {24'h0, b0};
      OP_LHU:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU}) begin
      mem_rdata <= ld_val(mem_op, mem_addr);
    end else begin
      mem_rdata <= 32'h0;
      if (mem_addr[31:20] == 12'h000) begin
        if (mem_op inside {OP_SB, OP_SH, OP_SW}) wr_b(mem_addr, mem_wdata[7:0]);
        if (mem_op inside {OP_SH, OP_SW})        wr_b(mem_addr + 32'd1, mem_wdata[15:8]);
        if (mem_op == OP_SW) begin
          wr_b(mem_addr + 32'd2, mem_wdata[23:16]);
          wr_b(mem_addr + 32'd3, mem_wdata[31:24]);
        end
      end
    end
  end

  // ---------------- reference model: per-cycle expectations keyed by cycle number ----------------
  logic [3:0]  ex_op    [int];
  logic [31:0] ex_addr  [int];
  logic [31:0] ex_wdata [int];
  bit          ex_busy  [int];
  logic [1:0]  ex_done  [int];
  logic [31:0] lr_at    [int];
  logic [31:0] fa_at    [int];
  int          next_free = 0;
  logic [31:0] model_lr = 32'h0;
  logic [31:0] model_fa = 32'h0;

  task automatic classify(input logic st, input logic [2:0] f3, input logic [31:0] ea,
                          output logic [1:0] f, output logic [3:0] op);
    bit legal;
    logic [31:0] size;
    legal = 1'b1;
    op = OP_NON;
    if (st) begin
      if (f3 > 3'd2) legal = 1'b0;
      else op = OP_SB + {1'b0, f3};
    end else begin
      if (f3 == 3'd3 || f3 > 3'd5) legal = 1'b0;
      else if (f3 < 3'd3) op = OP_LB + {1'b0, f3};
      else op = OP_LBU + {1'b0, f3} - 4'd4;
    end
    size = 32'd1 << f3[1:0];
    if (!legal) f = 2'd3;
    else if ((ea % size) != 32'd0) f = 2'd1;
    else if (ea >= 32'h0010_0000 && !(st && f3 == 3'd0 && ea == 32'h1300_0000)) f = 2'd2;
    else f = 2'd0;
  endtask

  function automatic int latency(input logic [1:0] f, input logic st);
    if (f != 2'd0) return 1;
    return st ? 2 : 3;
  endfunction

  task automatic model_accept(input int e, input logic st, input logic [2:0] f3,
                              input logic [31:0] ea, input logic [31:0] sd);
    logic [1:0] f;
    logic [3:0] op;
    int lat;
    classify(st, f3, ea, f, op);
    lat = latency(f, st);
    if (f == 2'd0) begin
      ex_op[e] = op; ex_addr[e] = ea; ex_wdata[e] = sd;
      if (!st) lr_at[e + 2] = ld_val(op, ea);
    end else begin
      fa_at[e] = ea;
    end
    for (int c = e; c <= e + lat - 2; c++) ex_busy[c] = 1'b1;
    ex_done[e + lat - 1] = f;
    next_free = e + lat + 1;
  endtask

  task automatic model_reset();
    ex_op.delete(); ex_addr.delete(); ex_wdata.delete(); ex_busy.delete();
    ex_done.delete(); lr_at.delete(); fa_at.delete();
    model_lr = 32'h0; model_fa = 32'h0; next_free = 0;
  endtask

  // Called just after a negedge: sets inputs for the coming edge and tells the model if it accepts.
  task automatic drive_cycle(input logic s, input logic st, input logic [2:0] f3,
                             input logic [31:0] b, input logic [31:0] i, input logic [31:0] sd);
    start = s; is_store = st; funct3 = f3; base = b; imm = i; store_data = sd;
    if (s && (cyc + 1 >= next_free)) model_accept(cyc + 1, st, f3, b + i, sd);
  endtask

  // ---------------- compare process ----------------
  logic [3:0] exp_op;
  always @(negedge clk) begin
    if (!reset) begin
      if (lr_at.exists(cyc)) model_lr = lr_at[cyc];
      if (fa_at.exists(cyc)) model_fa = fa_at[cyc];
      exp_op = ex_op.exists(cyc) ? ex_op[cyc] : OP_NON;
      check("mem_op", 32'(mem_op), 32'(exp_op));
      if (exp_op != OP_NON) begin
        check("mem_addr", mem_addr, ex_addr[cyc]);
        check("mem_wdata", mem_wdata, ex_wdata[cyc]);
      end
      check("busy", 32'(busy), ex_busy.exists(cyc) ? 32'd1 : 32'd0);
      check("done", 32'(done), ex_done.exists(cyc) ? 32'd1 : 32'd0);
      if (ex_done.exists(cyc)) check("fault", 32'(fault), 32'(ex_done[cyc]));
      check("load_result", load_result, model_lr);
      check("fault_addr", fault_addr, model_fa);
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] b,
                     input logic [31:0] i, input logic [31:0] sd);
    logic [1:0] f;
    logic [3:0] op;
    while (cyc + 1 < next_free) @(negedge clk);
    classify(st, f3, b + i, f, op);
    drive_cycle(1'b1, st, f3, b, i, sd);
    @(negedge clk);
    start = 1'b0;
    repeat (latency(f, st) - 1) @(negedge clk);
  endtask

  initial begin
    int n_done, n_acc, kind;
    logic        s, st;
    logic [2:0]  f3;
    logic [31:0] ea, b, sd;

    repeat (3) @(negedge clk);
    check("rst_mem_op", 32'(mem_op), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_load_result", load_result, 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    reset = 1'b0;

    wr_b(32'h104, 8'h78); wr_b(32'h105, 8'h56); wr_b(32'h106, 8'h34); wr_b(32'h107, 8'h12);
    wr_b(32'h40, 8'h9C);
    @(negedge clk);

    req(1'b0, 3'd2, 32'h100, 32'd4, 32'h0);
    check("lw_done", 32'(done), 32'd1);
    check("lw_fault", 32'(fault), 32'd0);
    check("lw_result", load_result, 32'h1234_5678);

    req(1'b1, 3'd2, 32'h200, 32'hFFFF_FFF8, 32'hCAFE_BABE);
    check("sw_done", 32'(done), 32'd1);
    check("sw_result_kept", load_result, 32'h1234_5678);
    check("sw_mem_word", {rd_b(32'h1FB), rd_b(32'h1FA), rd_b(32'h1F9), rd_b(32'h1F8)}, 32'hCAFE_BABE);

    req(1'b0, 3'd1, 32'h300, 32'd1, 32'h0);
    check("lh_mis_done", 32'(done), 32'd1);
    check("lh_mis_fault", 32'(fault), 32'd1);
    check("lh_mis_addr", fault_addr, 32'h301);

    req(1'b0, 3'd2, 32'h300, 32'd2, 32'h0);
    check("lw_mis_fault", 32'(fault), 32'd1);

    req(1'b0, 3'd3, 32'h400, 32'd0, 32'h0);
    check("ld_illegal_fault", 32'(fault), 32'd3);

    req(1'b1, 3'd0, 32'h1300_0000, 32'd0, 32'h41);
    check("sb_console_fault", 32'(fault), 32'd0);

    req(1'b1, 3'd1, 32'h1300_0000, 32'd0, 32'h4142);
    check("sh_console_fault", 32'(fault), 32'd2);
    check("sh_console_addr", fault_addr, 32'h1300_0000);

    req(1'b0, 3'd2, 32'h0010_0000, 32'd0, 32'h0);
    check("lw_range_fault", 32'(fault), 32'd2);
    check("result_after_faults", load_result, 32'h1234_5678);

    // start held through a whole load: one access, one done
    while (cyc + 1 < next_free) @(negedge clk);
    n_done = 0; n_acc = 0;
    for (int j = 0; j < 4; j++) begin
      drive_cycle(1'b1, 1'b0, 3'd2, 32'h100, 32'd4, 32'h0);
      @(negedge clk);
      n_done += int'(done); n_acc += (mem_op != OP_NON) ? 1 : 0;
    end
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_done += int'(done); n_acc += (mem_op != OP_NON) ? 1 : 0;
    end
    check("held_start_dones", 32'(n_done), 32'd1);
    check("held_start_accesses", 32'(n_acc), 32'd1);

    // reset in the ACCESS cycle of a store
    while (cyc + 1 < next_free) @(negedge clk);
    drive_cycle(1'b1, 1'b1, 3'd2, 32'h500, 32'd0, 32'h1122_3344);
    @(posedge clk);
    #2 reset = 1'b1;
    start = 1'b0;
    model_reset();
    #1;
    check("midrst_mem_op", 32'(mem_op), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req(1'b0, 3'd0, 32'h40, 32'd0, 32'h0);
    check("lb_after_rst", load_result, 32'hFFFF_FF9C);
    check("lb_after_rst_fault", 32'(fault), 32'd0);

    // randomized traffic, including start pulses while busy
    for (int n = 0; n < 3000; n++) begin
      kind = int'($urandom_range(0, 7));
      case (kind)
        0, 1, 2, 3: ea = $urandom & 32'h000F_FFFF;
        4:          ea = 32'h1300_0000;
        5:          ea = $urandom;
        6:          ea = 32'h000F_FFF0 + $urandom_range(0, 15);
        default:    ea = 32'h0010_0000 + $urandom_range(0, 15);
      endcase
      if ($urandom_range(0, 1) == 1) ea[1:0] = 2'b00;
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      b  = $urandom;
      sd = $urandom;
      s  = ($urandom_range(0, 2) == 0);
      drive_cycle(s, st, f3, b, ea - b, sd);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
